rip_axi_mem_responder: RTL and testbench
========================================

# rip_axi_mem_responder

AXI4 slave memory model that answers the AXI master port of the core-side MMU on board and simulation test benches. It accepts write bursts (AW/W/B) and read bursts (AR/R) on independent channel state machines. Data lives in a word-addressed internal array. Each transfer gets an OKAY, SLVERR or DECERR response, so MMU fill and write-back traffic can run without external DRAM.

## Interface
- ADDR_WIDTH, 32, AXI address width.
- AXI_ID_WIDTH, 4, transaction ID width; IDs are echoed unchanged.
- AXI_DATA_WIDTH, 32, data bus width; BYTES = AXI_DATA_WIDTH/8.
- MEM_WORDS, 1024, array depth in AXI_DATA_WIDTH words; power of two.
- BASE_ADDR, 0, byte address of word 0.

- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- S_AXI  rip_axi_interface.slave  —  full AXI4 slave port: aw*, w*, b*, ar*, r* channels

## Operation
- **Write FSM**
  - W_IDLE: awready=1. AW handshake latches id, addr, len, burst, size; beat counter is cleared; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes selected by wstrb to the current word, then advances the address.
  - When the beat count reaches awlen, or on wlast, go to W_RESP.
  - W_RESP: bvalid=1 and bid = latched id; hold until bready, then return to W_IDLE.
- **Read FSM**
  - R_IDLE: arready=1. AR handshake latches the request; go to R_FETCH.
  - R_FETCH: array read is registered into rdata; go to R_DATA.
  - R_DATA: rvalid=1, rlast on beat arlen, rid = latched id. Handshake ends the burst on the last beat (back to R_IDLE); otherwise advance the address and return to R_FETCH.
- **Address generation**
  - word index = (addr − BASE_ADDR) >> log2(BYTES), taken modulo 2^ADDR_WIDTH.
  - FIXED: address does not change.
  - INCR: addr += BYTES.
- **Error responses**
  - Out of range (addr < BASE_ADDR, or index ≥ MEM_WORDS), checked per beat: DECERR. Writes are dropped; reads return rdata=0.
  - size ≠ log2(BYTES), or reserved burst type: SLVERR on every beat. No array write occurs.
  - wlast mismatch (early, or missing on the final beat): burst ends at the earlier of wlast or beat awlen; bresp=SLVERR.
  - bresp reports the worst beat, ordered DECERR > SLVERR > OKAY.
- **Read/write interaction**
  - Both FSMs run concurrently.
  - An array read and an array write to the same word in the same cycle return the old data (read-first).
- **Reset**
  - FSMs go to IDLE.
  - bvalid=0, rvalid=0, rlast=0, wready=0, arready=1, awready=1, bresp=rresp=0, rdata=0.
  - Array contents are not reset.
  - Asserting rstn mid-burst aborts the burst immediately; no response is issued.

## Timing
- Write:
  - AW handshake at edge N: wready=1 from N+1.
  - Throughput is one beat per cycle; the array updates on the handshake edge.
  - Last-beat handshake at M: bvalid=1 from M+1.
  - B handshake at K: awready=1 from K+1.
- Read:
  - AR handshake at N: rvalid=1 from N+2.
  - Each R handshake at K: next beat rvalid from K+2. Throughput is one beat per 2 cycles.
- valid stays asserted, and payload stays stable, until its handshake.
- ready signals are decoded from state only; no combinational path from any valid input to any ready output.

## Configuration
- RIP_AXI_MEM_WRAP_EN defined:
  - WRAP bursts are supported. len must be 1, 3, 7 or 15, and addr must be BYTES-aligned; otherwise SLVERR.
  - mask = (len+1)·BYTES−1.
  - next = (addr & ~mask) | ((addr+BYTES) & mask).
- Undefined: WRAP is treated as a reserved burst type (SLVERR on every beat, no write).

## Structure
- Add to rip_const:
  - response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - burst enum BURST_FIXED/INCR/WRAP.
- Sub-module rip_axi_burst_addr_gen (combinational next-address and range/error check):
  - inputs: addr, len, size, burst;
  - one instance each for the write and read channels.
- The array is an inferred simple dual-port RAM: one write port, one registered read port.

## Test plan
- INCR write, awaddr=0x10, len=3, wdata 0xA0..0xA3, wstrb=4'hF -> bresp=OKAY, bid echoed. INCR read of the same range returns 0xA0..0xA3 with rlast on beat 3.
- Single write of 0xDEADBEEF, then 0x11223344 with wstrb=4'b0101 to the same word -> read returns 0xDE22BE44.
- Write to BASE_ADDR+MEM_WORDS·BYTES -> bresp=DECERR and the array is unchanged. Read of the same address -> rdata=0, rresp=DECERR.
- awlen=3 with wlast on beat 1 -> burst ends after 2 beats, bresp=SLVERR. Next AW is accepted the cycle after bready.
- With the macro defined, WRAP len=3 at 0x18 -> beats hit 0x18, 0x1C, 0x10, 0x14. Without the macro, the same read returns SLVERR on every beat.
- rstn pulsed low during beat 2 of an 8-beat read -> rvalid drops immediately and arready=1. A subsequent read returns previously written data (array retained).

Source files
------------

// File: rtl/rip_axi_mem_responder_pkg.sv
// Shared AXI constants: response codes, burst types and FSM state encodings.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rip_const;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    // Response codes are ordered so that the numerically larger one is the worse one.
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rip_axi_mem_responder_if.sv
// Full AXI4 bus bundle (AW/W/B/AR/R) with master and slave views.
// Latency: none (wiring only).
// Backpressure: standard valid/ready on every channel.
interface rip_axi_interface #(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]       awaddr;
    logic [7:0]                  awlen;
    logic [2:0]                  awsize;
    logic [1:0]                  awburst;
    logic                        awvalid;
    logic                        awready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wlast;
    logic                        wvalid;
    logic                        wready;
    logic [AXI_ID_WIDTH-1:0]     bid;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [AXI_ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]       araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arvalid;
    logic                        arready;
    logic [AXI_ID_WIDTH-1:0]     rid;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic                        rvalid;
    logic                        rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/rip_axi_burst_addr_gen.sv
// Next beat address, word index and per-beat DECERR/SLVERR classification.
// Latency: combinational. Backpressure: none.
// WRAP bursts are legal only when RIP_AXI_MEM_WRAP_EN is defined.
module rip_axi_burst_addr_gen
    import rip_const::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    AXI_DATA_WIDTH = 32,
    parameter int                    MEM_WORDS      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [7:0]                   len,
    input  logic [2:0]                   size,
    input  logic [1:0]                   burst,
    output logic [ADDR_WIDTH-1:0]        next_addr,
    output logic [$clog2(MEM_WORDS)-1:0] idx,
    output logic                         decerr,
    output logic                         slverr
);
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int IW    = $clog2(MEM_WORDS);

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] wrap_next;

    always_comb begin
        offset    = addr - BASE_ADDR;
        word      = offset >> LB;
        idx       = word[IW-1:0];
        decerr    = (addr < BASE_ADDR) || (word >= ADDR_WIDTH'(MEM_WORDS));
        mask      = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << LB) - ADDR_WIDTH'(1);
        wrap_next = (addr & ~mask) | ((addr + ADDR_WIDTH'(BYTES)) & mask);
        slverr    = (size != 3'(LB));
        next_addr = addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_INCR:  next_addr = addr + ADDR_WIDTH'(BYTES);
            BURST_WRAP: begin
                next_addr = wrap_next;
`ifdef RIP_AXI_MEM_WRAP_EN
                if (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                    ((addr & ADDR_WIDTH'(BYTES - 1)) != '0))
                    slverr = 1'b1;
`else
                slverr = 1'b1;
`endif
            end
            default: slverr = 1'b1;
        endcase
    end

endmodule

// File: rtl/rip_axi_mem_responder.sv
// AXI4 slave memory model: independent write (AW/W/B) and read (AR/R) FSMs over a word array.
// Latency: W beat per cycle, B one cycle after the last beat; R beat two cycles after AR or prior R.
// Backpressure: valid held with stable payload until ready; readies come from state only. Macro: RIP_AXI_MEM_WRAP_EN.
module rip_axi_mem_responder
    import rip_const::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    AXI_ID_WIDTH   = 4,
    parameter int                    AXI_DATA_WIDTH = 32,
    parameter int                    MEM_WORDS      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic             clk,
    input  logic             rstn,
    rip_axi_interface.slave  S_AXI
);
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int IW    = $clog2(MEM_WORDS);

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] w_addr, w_next;
    logic [7:0]            w_len, w_beat;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [IW-1:0]         w_idx;
    logic                  w_dec, w_slv, w_final, mem_we;
    logic [1:0]            w_beat_resp;

    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] r_addr, r_next;
    logic [7:0]            r_len, r_beat;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [IW-1:0]         r_idx;
    logic                  r_dec, r_slv;

    rip_axi_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
        .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)
    ) u_wr_gen (
        .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst),
        .next_addr(w_next), .idx(w_idx), .decerr(w_dec), .slverr(w_slv)
    );

    rip_axi_burst_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
        .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE_ADDR)
    ) u_rd_gen (
        .addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst),
        .next_addr(r_next), .idx(r_idx), .decerr(r_dec), .slverr(r_slv)
    );

    assign w_beat_resp = w_dec ? RESP_DECERR : (w_slv ? RESP_SLVERR : RESP_OKAY);
    assign w_final     = S_AXI.wlast || (w_beat == w_len);
    assign mem_we      = (w_state == W_DATA) && S_AXI.wvalid && !w_dec && !w_slv;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (S_AXI.wstrb[b]) mem[w_idx][b*8 +: 8] <= S_AXI.wdata[b*8 +: 8];
            end
        end
    end

    // bresp doubles as the running worst-beat accumulator; it is cleared on AW.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state       <= W_IDLE;
            S_AXI.awready <= 1'b1;
            S_AXI.wready  <= 1'b0;
            S_AXI.bvalid  <= 1'b0;
            S_AXI.bresp   <= RESP_OKAY;
            S_AXI.bid     <= '0;
            w_addr        <= '0;
            w_len         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
            w_beat        <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (S_AXI.awvalid) begin
                    S_AXI.bid     <= S_AXI.awid;
                    S_AXI.bresp   <= RESP_OKAY;
                    S_AXI.awready <= 1'b0;
                    S_AXI.wready  <= 1'b1;
                    w_addr        <= S_AXI.awaddr;
                    w_len         <= S_AXI.awlen;
                    w_size        <= S_AXI.awsize;
                    w_burst       <= S_AXI.awburst;
                    w_beat        <= '0;
                    w_state       <= W_DATA;
                end
                W_DATA: if (S_AXI.wvalid) begin
                    if (w_final) begin
                        S_AXI.bresp  <= resp_worst(resp_worst(S_AXI.bresp, w_beat_resp),
                                        (S_AXI.wlast != (w_beat == w_len)) ? RESP_SLVERR : RESP_OKAY);
                        S_AXI.wready <= 1'b0;
                        S_AXI.bvalid <= 1'b1;
                        w_state      <= W_RESP;
                    end else begin
                        S_AXI.bresp <= resp_worst(S_AXI.bresp, w_beat_resp);
                        w_beat      <= w_beat + 8'd1;
                        w_addr      <= w_next;
                    end
                end
                W_RESP: if (S_AXI.bready) begin
                    S_AXI.bvalid  <= 1'b0;
                    S_AXI.awready <= 1'b1;
                    w_state       <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // R_FETCH is the registered read port; errored beats return zero data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= R_IDLE;
            S_AXI.arready <= 1'b1;
            S_AXI.rvalid  <= 1'b0;
            S_AXI.rlast   <= 1'b0;
            S_AXI.rresp   <= RESP_OKAY;
            S_AXI.rdata   <= '0;
            S_AXI.rid     <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            r_beat        <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (S_AXI.arvalid) begin
                    S_AXI.rid     <= S_AXI.arid;
                    S_AXI.arready <= 1'b0;
                    r_addr        <= S_AXI.araddr;
                    r_len         <= S_AXI.arlen;
                    r_size        <= S_AXI.arsize;
                    r_burst       <= S_AXI.arburst;
                    r_beat        <= '0;
                    r_state       <= R_FETCH;
                end
                R_FETCH: begin
                    S_AXI.rdata  <= (r_dec || r_slv) ? '0 : mem[r_idx];
                    S_AXI.rresp  <= r_dec ? RESP_DECERR : (r_slv ? RESP_SLVERR : RESP_OKAY);
                    S_AXI.rlast  <= (r_beat == r_len);
                    S_AXI.rvalid <= 1'b1;
                    r_state      <= R_DATA;
                end
                R_DATA: if (S_AXI.rready) begin
                    S_AXI.rvalid <= 1'b0;
                    if (S_AXI.rlast) begin
                        S_AXI.rlast   <= 1'b0;
                        S_AXI.arready <= 1'b1;
                        r_state       <= R_IDLE;
                    end else begin
                        r_beat  <= r_beat + 8'd1;
                        r_addr  <= r_next;
                        r_state <= R_FETCH;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rip_axi_mem_responder.sv
// Directed and randomized bench for rip_axi_mem_responder against a word-array reference model.
module tb_rip_axi_mem_responder;

`ifdef RIP_AXI_MEM_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif
    localparam logic [31:0] BASE  = 32'h0;
    localparam int          WORDS = 1024;

    logic clk;
    logic rstn;

    rip_axi_interface #(.ADDR_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_DATA_WIDTH(32)) axi ();

    rip_axi_mem_responder #(
        .ADDR_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_DATA_WIDTH(32),
        .MEM_WORDS(WORDS), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rstn(rstn), .S_AXI(axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mm [WORDS];
    logic [31:0] wq_data [$];
    logic [3:0]  wq_strb [$];
    logic [31:0] rd_q [$];
    logic [1:0]  rr_q [$];
    logic        rl_q [$];
    logic [31:0] ed_q [$];
    logic [1:0]  er_q [$];
    logic        el_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] addr, input logic [7:0] len,
                                          input logic [1:0] burst, input logic [2:0] size);
        logic [31:0] diff;
        bit slv, dec;
        slv = (size != 3'd2) || (burst == 2'b11);
        if (burst == 2'b10)
            slv = slv || !WRAP_EN || !(len == 1 || len == 3 || len == 7 || len == 15) || (addr % 4 != 0);
        diff = addr - BASE;
        dec  = (addr < BASE) || ((diff / 4) >= WORDS);
        return dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] addr, input logic [7:0] len,
                                           input logic [1:0] burst);
        logic [31:0] span, lo, nxt;
        if (burst == 2'b00) return addr;
        if (burst == 2'b10) begin
            span = (32'(len) + 1) * 4;
            lo   = addr - (addr % span);
            nxt  = addr + 4;
            return (nxt >= lo + span) ? lo : nxt;
        end
        return addr + 4;
    endfunction

    function automatic int m_idx(input logic [31:0] addr);
        logic [31:0] diff;
        diff = addr - BASE;
        return int'((diff / 4) % WORDS);
    endfunction

    // Applies the beats in wq_* to the model and returns the expected bresp.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [7:0] len,
                                               input logic [1:0] burst, input logic [2:0] size,
                                               input int last_beat);
        logic [31:0] a;
        logic [1:0]  worst, r;
        int nb, i;
        a = addr;
        worst = 2'b00;
        nb = (last_beat < int'(len)) ? last_beat + 1 : int'(len) + 1;
        for (int b = 0; b < nb; b++) begin
            r = m_resp(a, len, burst, size);
            if (r == 2'b00) begin
                i = m_idx(a);
                for (int k = 0; k < 4; k++)
                    if (wq_strb[b][k]) mm[i][k*8 +: 8] = wq_data[b][k*8 +: 8];
            end
            worst = worse(worst, r);
            a = m_next(a, len, burst);
        end
        if (last_beat != int'(len)) worst = worse(worst, 2'b10);
        return worst;
    endfunction

    task automatic model_read(input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [2:0] size);
        logic [31:0] a;
        logic [1:0]  r;
        a = addr;
        ed_q.delete(); er_q.delete(); el_q.delete();
        for (int b = 0; b <= int'(len); b++) begin
            r = m_resp(a, len, burst, size);
            ed_q.push_back((r == 2'b00) ? mm[m_idx(a)] : 32'h0);
            er_q.push_back(r);
            el_q.push_back(b == int'(len));
            a = m_next(a, len, burst);
        end
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input int last_beat,
                             output logic [1:0] resp);
        int n, nb;
        nb = (last_beat < int'(len)) ? last_beat + 1 : int'(len) + 1;
        axi.awid = id; axi.awaddr = addr; axi.awlen = len; axi.awburst = burst; axi.awsize = size;
        axi.awvalid = 1'b1;
        n = 0;
        while (axi.awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check("aw_timeout", n < 50, 1);
        @(posedge clk); #1;
        axi.awvalid = 1'b0;
        check("wready_after_aw", axi.wready, 1'b1);
        for (int b = 0; b < nb; b++) begin
            axi.wvalid = 1'b1; axi.wdata = wq_data[b]; axi.wstrb = wq_strb[b];
            axi.wlast = (b == last_beat);
            n = 0;
            while (axi.wready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
            if (n != 0) check("w_beat_stall", n, 0);
            @(posedge clk); #1;
        end
        axi.wvalid = 1'b0; axi.wlast = 1'b0;
        check("bvalid_after_last", axi.bvalid, 1'b1);
        axi.bready = 1'b1;
        n = 0;
        while (axi.bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check("bid", axi.bid, id);
        resp = axi.bresp;
        @(posedge clk); #1;
        axi.bready = 1'b0;
        check("awready_after_b", axi.awready, 1'b1);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
        int n;
        rd_q.delete(); rr_q.delete(); rl_q.delete();
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arburst = burst; axi.arsize = size;
        axi.arvalid = 1'b1;
        n = 0;
        while (axi.arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check("ar_timeout", n < 50, 1);
        @(posedge clk); #1;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (axi.rvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
            check("r_latency", n, 1);
            check("rid", axi.rid, id);
            rd_q.push_back(axi.rdata); rr_q.push_back(axi.rresp); rl_q.push_back(axi.rlast);
            @(posedge clk); #1;
        end
        axi.rready = 1'b0;
        check("arready_after_last", axi.arready, 1'b1);
    endtask

    task automatic compare_read(input string tag);
        check({tag, "_beats"}, rd_q.size(), ed_q.size());
        for (int i = 0; i < ed_q.size() && i < rd_q.size(); i++) begin
            check({tag, "_rdata"}, rd_q[i], ed_q[i]);
            check({tag, "_rresp"}, rr_q[i], er_q[i]);
            check({tag, "_rlast"}, rl_q[i], el_q[i]);
        end
    endtask

    task automatic fill_wq(input int n, input logic [31:0] base_val, input bit rnd);
        wq_data.delete(); wq_strb.delete();
        for (int i = 0; i < n; i++) begin
            wq_data.push_back(rnd ? $urandom : base_val + 32'(i));
            wq_strb.push_back(rnd ? 4'($urandom_range(0, 15)) : 4'hF);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp, exp_resp;
        logic [31:0] addr, w0;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        int          lb, n, sel;

        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
        axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", axi.awready, 1'b1);
        check("rst_arready", axi.arready, 1'b1);
        check("rst_wready",  axi.wready,  1'b0);
        check("rst_bvalid",  axi.bvalid,  1'b0);
        check("rst_rvalid",  axi.rvalid,  1'b0);
        check("rst_rlast",   axi.rlast,   1'b0);
        check("rst_bresp",   axi.bresp,   2'b00);
        check("rst_rresp",   axi.rresp,   2'b00);
        check("rst_rdata",   axi.rdata,   32'h0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Preload the whole array so every later read has a known model value.
        for (int blk = 0; blk < WORDS / 16; blk++) begin
            fill_wq(16, 32'h0, 1'b1);
            for (int i = 0; i < 16; i++) wq_strb[i] = 4'hF;
            exp_resp = model_write(32'(blk * 64), 8'd15, 2'b01, 3'd2, 15);
            axi_write(4'(blk), 32'(blk * 64), 8'd15, 2'b01, 3'd2, 15, resp);
            check("preload_bresp", resp, exp_resp);
        end

        // INCR write/read of four words.
        fill_wq(4, 32'hA0, 1'b0);
        exp_resp = model_write(32'h10, 8'd3, 2'b01, 3'd2, 3);
        axi_write(4'd5, 32'h10, 8'd3, 2'b01, 3'd2, 3, resp);
        check("incr_bresp", resp, 2'b00);
        model_read(32'h10, 8'd3, 2'b01, 3'd2);
        axi_read(4'd9, 32'h10, 8'd3, 2'b01, 3'd2);
        compare_read("incr_rd");
        check("incr_rd_beat3", rd_q[3], 32'hA3);
        check("incr_rd_rlast2", rl_q[2], 1'b0);

        // Byte-strobed overwrite.
        fill_wq(1, 32'hDEADBEEF, 1'b0);
        exp_resp = model_write(32'h40, 8'd0, 2'b01, 3'd2, 0);
        axi_write(4'd1, 32'h40, 8'd0, 2'b01, 3'd2, 0, resp);
        wq_data[0] = 32'h11223344; wq_strb[0] = 4'b0101;
        exp_resp = model_write(32'h40, 8'd0, 2'b01, 3'd2, 0);
        axi_write(4'd2, 32'h40, 8'd0, 2'b01, 3'd2, 0, resp);
        check("strb_bresp", resp, exp_resp);
        model_read(32'h40, 8'd0, 2'b01, 3'd2);
        axi_read(4'd3, 32'h40, 8'd0, 2'b01, 3'd2);
        compare_read("strb_rd");
        check("strb_rd_const", rd_q[0], 32'hDE22BE44);

        // Just past the top of the array: dropped write and zero read data.
        w0 = mm[0];
        fill_wq(1, 32'h55AA55AA, 1'b0);
        exp_resp = model_write(BASE + WORDS * 4, 8'd0, 2'b01, 3'd2, 0);
        axi_write(4'd4, BASE + WORDS * 4, 8'd0, 2'b01, 3'd2, 0, resp);
        check("oor_bresp", resp, 2'b11);
        check("oor_bresp_model", resp, exp_resp);
        axi_read(4'd6, 32'h0, 8'd0, 2'b01, 3'd2);
        check("oor_word0_kept", rd_q[0], w0);
        model_read(BASE + WORDS * 4, 8'd0, 2'b01, 3'd2);
        axi_read(4'd7, BASE + WORDS * 4, 8'd0, 2'b01, 3'd2);
        compare_read("oor_rd");
        check("oor_rresp", rr_q[0], 2'b11);

        // Early wlast on beat 1 of a 4-beat burst.
        fill_wq(4, 32'hC0, 1'b0);
        exp_resp = model_write(32'h200, 8'd3, 2'b01, 3'd2, 1);
        axi_write(4'd8, 32'h200, 8'd3, 2'b01, 3'd2, 1, resp);
        check("early_wlast_bresp", resp, 2'b10);
        model_read(32'h200, 8'd3, 2'b01, 3'd2);
        axi_read(4'd8, 32'h200, 8'd3, 2'b01, 3'd2);
        compare_read("early_wlast_rd");

        // WRAP read of four words starting mid-block.
        fill_wq(4, 32'hB0, 1'b0);
        exp_resp = model_write(32'h10, 8'd3, 2'b01, 3'd2, 3);
        axi_write(4'd10, 32'h10, 8'd3, 2'b01, 3'd2, 3, resp);
        model_read(32'h18, 8'd3, 2'b10, 3'd2);
        axi_read(4'd11, 32'h18, 8'd3, 2'b10, 3'd2);
        compare_read("wrap_rd");
        if (WRAP_EN) begin
            check("wrap_beat2", rd_q[2], 32'hB0);
            check("wrap_beat3", rd_q[3], 32'hB1);
        end else begin
            check("wrap_rresp0", rr_q[0], 2'b10);
            check("wrap_rresp3", rr_q[3], 2'b10);
        end

        // Reset pulse while the second beat of an 8-beat read is presented.
        axi.arid = 4'd12; axi.araddr = 32'h100; axi.arlen = 8'd7; axi.arburst = 2'b01;
        axi.arsize = 3'd2; axi.arvalid = 1'b1;
        @(posedge clk); #1;
        axi.arvalid = 1'b0; axi.rready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            n = 0;
            while (axi.rvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
            if (b == 0) begin @(posedge clk); #1; end
        end
        check("midrst_rvalid_before", axi.rvalid, 1'b1);
        rstn = 1'b0;
        #1;
        check("midrst_rvalid", axi.rvalid, 1'b0);
        check("midrst_arready", axi.arready, 1'b1);
        check("midrst_rdata", axi.rdata, 32'h0);
        axi.rready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        @(posedge clk); #1;
        model_read(32'h100, 8'd7, 2'b01, 3'd2);
        axi_read(4'd13, 32'h100, 8'd7, 2'b01, 3'd2);
        compare_read("post_rst_rd");

        // Randomized traffic including out-of-range tails, bad size and wlast errors.
        for (int it = 0; it < 25; it++) begin
            addr  = 32'($urandom_range(0, WORDS + 6)) * 4;
            len   = 8'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 1));
            size  = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
            sel   = $urandom_range(0, 5);
            lb    = (sel == 0) ? $urandom_range(0, int'(len)) : ((sel == 1) ? 255 : int'(len));
            fill_wq(int'(len) + 1, 32'h0, 1'b1);
            exp_resp = model_write(addr, len, burst, size, lb);
            axi_write(4'($urandom), addr, len, burst, size, lb, resp);
            check("rnd_bresp", resp, exp_resp);

            addr  = 32'($urandom_range(0, WORDS + 6)) * 4;
            len   = 8'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 1));
            size  = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'd2;
            model_read(addr, len, burst, size);
            axi_read(4'($urandom), addr, len, burst, size);
            compare_read("rnd_rd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
